cva6_load_port_initiator: RTL

- Initiator side of the CVA6 load-port protocol (dcache_req_i_t / dcache_req_o_t): turns full-physical-address load commands into the two-phase index-then-tag request sequence.
- Tracks outstanding transactions by transaction ID (tid); matches possibly out-of-order responses; returns size-extracted data.
- Used as a load requester for non-core clients (PTW-style walkers, accelerators, bench traffic) in front of any load-port responder.

---
 rtl/cva6_load_init_pkg.sv | 77 +++++++
 rtl/cva6_load_init_tid_alloc.sv | 40 ++++
 rtl/cva6_load_port_initiator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cva6_load_init_pkg.sv
// Shared types and helpers for the CVA6 load-port initiator.
// CVA6_LOAD_INIT_SIGN_EXT_EN adds a per-tid sign-extension bit.
package cva6_load_init_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned PLEN               = 56;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;
    localparam int unsigned DCACHE_TID_WIDTH   = 2;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic [DCACHE_TID_WIDTH-1:0]   data_id;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic                        data_gnt;
        logic                        data_rvalid;
        logic [DCACHE_TID_WIDTH-1:0] data_rid;
        logic [XLEN-1:0]             data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [2:0] offset;
        size_e      size;
`ifdef CVA6_LOAD_INIT_SIGN_EXT_EN
        logic       sext;
`endif
        logic       killed;
    } entry_t;

    function automatic logic [7:0] be_from_size(size_e size, logic [2:0] offset);
        logic [7:0] m;
        unique case (size)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << offset;
    endfunction

    function automatic logic [XLEN-1:0] extract_extend(logic [XLEN-1:0] rdata, entry_t e);
        logic [XLEN-1:0] sh;
        logic            sx;
        logic [XLEN-1:0] r;
        sh = rdata >> {e.offset, 3'b000};
`ifdef CVA6_LOAD_INIT_SIGN_EXT_EN
        sx = e.sext;
`else
        sx = 1'b0;
`endif
        unique case (e.size)
            SIZE_B:  r = {{(XLEN-8){sx & sh[7]}},   sh[7:0]};
            SIZE_H:  r = {{(XLEN-16){sx & sh[15]}}, sh[15:0]};
            SIZE_W:  r = {{(XLEN-32){sx & sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cva6_load_init_tid_alloc.sv
// Transaction-ID free list: lowest-free allocation; a freed tid is only
// visible to the allocator from the following cycle.
module cva6_load_init_tid_alloc #(
    parameter int unsigned NumIds = 4,
    parameter int unsigned IdW    = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_i,
    input  logic              free_i,
    input  logic [IdW-1:0]    free_id_i,
    output logic              avail_o,
    output logic [IdW-1:0]    alloc_id_o,
    output logic [NumIds-1:0] free_mask_o
);

    logic [NumIds-1:0] free_q, free_d;

    always_comb begin
        alloc_id_o = '0;
        for (int i = int'(NumIds) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_id_o = IdW'(i);
        end
    end

    assign avail_o     = |free_q;
    assign free_mask_o = free_q;

    always_comb begin
        free_d = free_q;
        if (free_i)  free_d[free_id_i]  = 1'b1;
        if (alloc_i) free_d[alloc_id_o] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) free_q <= '1;
        else         free_q <= free_d;
    end

endmodule

// File: rtl/cva6_load_port_initiator.sv
// Load-port initiator: index/tag request sequencing, tid tracking and
// out-of-order response extraction. Macro: CVA6_LOAD_INIT_SIGN_EXT_EN.
module cva6_load_port_initiator
    import cva6_load_init_pkg::*;
#(
    parameter int unsigned NumIds    = 4,
    parameter int unsigned PlenWidth = PLEN
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [PlenWidth-1:0]        cmd_paddr_i,
    input  logic [1:0]                  cmd_size_i,
    input  logic                        cmd_signed_i,
    input  logic                        cmd_kill_i,
    output dcache_req_i_t               req_o,
    input  dcache_req_o_t               req_i,
    output logic                        rsp_valid_o,
    output logic [XLEN-1:0]             rsp_data_o,
    output logic [DCACHE_TID_WIDTH-1:0] rsp_id_o,
    output logic                        rsp_killed_o,
    output logic                        busy_o
);

    typedef enum logic {IDLE, REQ} state_e;

    state_e                        state_q, state_d;
    logic [PlenWidth-1:0]          req_paddr_q, req_paddr_d;
    size_e                         req_size_q, req_size_d;
    logic [DCACHE_TID_WIDTH-1:0]   req_tid_q, req_tid_d;
    logic                          req_kill_q, req_kill_d;
    logic                          tag_valid_q;
    logic [DCACHE_TAG_WIDTH-1:0]   tag_q;
    logic                          tag_kill_q;
    entry_t                        entries_q [NumIds];
    entry_t                        new_entry;
    logic                          rsp_valid_q, rsp_killed_q;
    logic [XLEN-1:0]               rsp_data_q;
    logic [DCACHE_TID_WIDTH-1:0]   rsp_id_q;

    logic                          avail, grant, accept, rsp_hit;
    logic [DCACHE_TID_WIDTH-1:0]   alloc_id;
    logic [NumIds-1:0]             free_mask;

    cva6_load_init_tid_alloc #(.NumIds(NumIds), .IdW(DCACHE_TID_WIDTH)) i_tid_alloc (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_i     (accept),
        .free_i      (rsp_hit),
        .free_id_i   (req_i.data_rid),
        .avail_o     (avail),
        .alloc_id_o  (alloc_id),
        .free_mask_o (free_mask)
    );

    assign grant       = (state_q == REQ) && req_i.data_gnt;
    assign cmd_ready_o = rst_ni && avail && ((state_q == IDLE) || grant);
    assign accept      = cmd_valid_i && cmd_ready_o;
    // Responses for tids we never handed out (e.g. stale after reset) are dropped.
    assign rsp_hit     = req_i.data_rvalid && (32'(req_i.data_rid) < NumIds)
                         && !free_mask[req_i.data_rid];

    always_comb begin
        new_entry        = '0;
        new_entry.offset = cmd_paddr_i[2:0];
        new_entry.size   = size_e'(cmd_size_i);
        new_entry.killed = cmd_kill_i;
`ifdef CVA6_LOAD_INIT_SIGN_EXT_EN
        new_entry.sext   = cmd_signed_i;
`endif
    end

`ifndef CVA6_LOAD_INIT_SIGN_EXT_EN
    logic unused_signed;
    assign unused_signed = cmd_signed_i;
`endif

    always_comb begin
        state_d     = state_q;
        req_paddr_d = req_paddr_q;
        req_size_d  = req_size_q;
        req_tid_d   = req_tid_q;
        req_kill_d  = req_kill_q;
        unique case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (grant && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            req_paddr_d = cmd_paddr_i;
            req_size_d  = size_e'(cmd_size_i);
            req_tid_d   = alloc_id;
            req_kill_d  = cmd_kill_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_paddr_q <= '0;
            req_size_q  <= SIZE_B;
            req_tid_q   <= '0;
            req_kill_q  <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
            tag_kill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_paddr_q <= req_paddr_d;
            req_size_q  <= req_size_d;
            req_tid_q   <= req_tid_d;
            req_kill_q  <= req_kill_d;
            // Tag phase lives in its own register so it overlaps the next index phase.
            tag_valid_q <= grant;
            if (grant) begin
                tag_q      <= req_paddr_q[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH];
                tag_kill_q <= req_kill_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumIds); i++) entries_q[i] <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_killed_q <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            if (accept) entries_q[alloc_id] <= new_entry;
            rsp_valid_q <= rsp_hit;
            if (rsp_hit) begin
                rsp_id_q     <= req_i.data_rid;
                rsp_killed_q <= entries_q[req_i.data_rid].killed;
                rsp_data_q   <= entries_q[req_i.data_rid].killed ? '0
                                : extract_extend(req_i.data_rdata, entries_q[req_i.data_rid]);
            end
        end
    end

    always_comb begin
        req_o = '0;
        if (state_q == REQ) begin
            req_o.data_req      = 1'b1;
            req_o.address_index = req_paddr_q[DCACHE_INDEX_WIDTH-1:0];
            req_o.data_be       = be_from_size(req_size_q, req_paddr_q[2:0]);
            req_o.data_size     = req_size_q;
            req_o.data_id       = req_tid_q;
        end
        if (tag_valid_q) begin
            req_o.tag_valid   = 1'b1;
            req_o.address_tag = tag_q;
            req_o.kill_req    = tag_kill_q;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_killed_o = rsp_killed_q;
    assign busy_o       = (state_q == REQ) || tag_valid_q || !(&free_mask);

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> ((cmd_paddr_i[2:0] & ((3'd1 << cmd_size_i) - 3'd1)) == 3'd0))
        else $error("misaligned load command");
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_i.data_rvalid |-> rsp_hit)
        else $warning("data_rvalid for unallocated tid dropped");
`endif

endmodule
